regbank_alu_sequencer: RTL
==========================

Name: regbank_alu_sequencer

Overview:
- Multi-cycle sequencer plus register bank that sits directly upstream of the 32-bit carry-lookahead adder.
- Holds 16 x 32-bit general registers and decodes one operation per request.
- Drives the adder's operand and carry-in inputs from registered values, then captures the adder's sum and carry-out and writes them back.
- The adder stays an external, purely combinational instance; this block owns all state, sequencing and flags.

Parameters:
- NREG, 16, number of registers; register index width = 4.
- DW, 32, datapath width; must equal the adder width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when ready=1.
- op  in  3  operation code: 000 ADD, 001 SUB, 010 ADDI, 011 MOVI, 100 READ; 101-111 illegal.
- rd  in  4  destination register index.
- rs1  in  4  source register 1 index.
- rs2  in  4  source register 2 index.
- imm  in  16  immediate; sign-extended for ADDI, zero-extended for MOVI.
- ready  out  1  1 only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for an illegal op.
- result  out  32  operation result; valid while done=1, held otherwise.
- flags  out  4  {C,Z,N,V}; updated only by ADD/SUB/ADDI.
- add_a  out  32  adder operand a.
- add_b  out  32  adder operand b.
- add_cin  out  1  adder carry-in.
- add_s  in  32  adder sum.
- add_cout  in  1  adder carry-out.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-operation):
  - state=IDLE; all registers, opA, opB, result, flags cleared to 0.
  - done=0, err=0, ready=1.
  - Any pending write-back is discarded.
- R0 reads as 0 always; writes to R0 are silently dropped (done still pulses).
- FSM states: IDLE -> FETCH -> EXEC -> WB -> IDLE.
  - IDLE: on start=1, latch op, rd, rs1, rs2, imm; go to FETCH. start is ignored in every other state.
  - FETCH: opA <= R[rs1].
    - ADD: opB <= R[rs2], cin=0.
    - SUB: opB <= ~R[rs2], cin=1.
    - ADDI: opB <= sext(imm), cin=0.
    - MOVI/READ/illegal: opB <= 0, cin=0.
  - EXEC:
    - add_a=opA, add_b=opB, add_cin=cin, all driven from registers.
    - At the end of the cycle, sum <= add_s, cout <= add_cout.
    - Outside EXEC, add_a/add_b/add_cin still reflect opA/opB/cin (no glitch requirement, value don't-care).
  - WB:
    - done=1.
    - ADD/SUB/ADDI: R[rd] <= sum; result=sum.
    - MOVI: R[rd] <= zext(imm); result=zext(imm).
    - READ: no write; result=R[rs1].
    - Illegal: no write, flags unchanged, result=0, err=1.
- Latency: start sampled at edge T -> done high in the cycle after edge T+3 (3 cycles busy after accept). Back-to-back throughput is one op per 4 cycles.
- Flags (ADD/SUB/ADDI only, written at the WB edge):
  - C = cout. For SUB, C=1 means no borrow.
  - Z = (sum==0).
  - N = sum[31].
  - V = (opA[31]==opB[31]) && (sum[31]!=opA[31]), with opB as fed to the adder.
- Read-after-write: a following op's FETCH sees the value written in the previous WB. No forwarding is needed.
- Wrap-around: ADD/SUB are modulo 2^32; overflow is reported only through C/V.

Test Plan:
- Reset then MOVI R1,0x1234 -> done 4 cycles after start; result=0x00001234; READ R1 returns 0x00001234; flags stay 0000.
- R2=0xFFFFFFFF via ADDI R2,R0,0xFFFF, then ADD R3,R2,R1 -> result=0x00001233; C=1, Z=0, N=0, V=0.
- SUB R4,R1,R1 -> add_b=0xFFFFEDCB, add_cin=1 during EXEC; result=0; flags C=1, Z=1, N=0, V=0.
- R5=0x7FFFFFFF built from MOVI/ADD steps, then ADDI R6,R5,1 -> result=0x80000000; C=0, Z=0, N=1, V=1.
- op=111 -> done=1 and err=1 on the same cycle; no register or flag changes. MOVI R0,0xBEEF -> READ R0 returns 0.
- Assert rst during EXEC of ADD R7,R1,R1 -> no done pulse; R7=0; ready=1 next cycle. start pulsed while busy (FETCH) -> ignored, only one done pulse.

Source files
------------

// File: rtl/regbank_alu_sequencer.sv
// Register bank plus four-phase sequencer feeding an external combinational adder.
// Each accepted request walks FETCH -> EXEC -> WB and then returns to IDLE.
module regbank_alu_sequencer #(
    parameter int NREG = 16,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [3:0]    rd,
    input  logic [3:0]    rs1,
    input  logic [3:0]    rs2,
    input  logic [15:0]   imm,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result,
    output logic [3:0]    flags,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    output logic          add_cin,
    input  logic [DW-1:0] add_s,
    input  logic          add_cout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_MOVI = 3'd3;
    localparam logic [2:0] OP_READ = 3'd4;

    logic [1:0]    state;
    logic [2:0]    op_q;
    logic [3:0]    rd_q;
    logic [3:0]    rs1_q;
    logic [3:0]    rs2_q;
    logic [15:0]   imm_q;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          cin;
    logic [DW-1:0] sum;
    logic          cout;
    logic [DW-1:0] result_q;
    logic [3:0]    flags_q;
    logic          done_q;
    logic          err_q;
    logic [DW-1:0] regs [NREG];

    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] sext_imm;
    logic [DW-1:0] zext_imm;
    logic [DW-1:0] fetch_b;
    logic          fetch_cin;
    logic          is_arith;
    logic          is_illegal;
    logic          wb_we;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] wb_result;
    logic          ovf;
    logic [3:0]    new_flags;

    // R0 is hardwired to zero on the read side; it is never written.
    assign rdata1 = (rs1_q == 4'd0) ? '0 : regs[rs1_q];
    assign rdata2 = (rs2_q == 4'd0) ? '0 : regs[rs2_q];

    assign sext_imm = {{(DW-16){imm_q[15]}}, imm_q};
    assign zext_imm = {{(DW-16){1'b0}}, imm_q};

    assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB)
                     || (op_q == OP_ADDI);
    assign is_illegal = (op_q > OP_READ);

    always_comb begin
        fetch_b   = '0;
        fetch_cin = 1'b0;
        unique case (op_q)
            OP_ADD:  fetch_b = rdata2;
            OP_SUB: begin
                fetch_b   = ~rdata2;
                fetch_cin = 1'b1;
            end
            OP_ADDI: fetch_b = sext_imm;
            default: fetch_b = '0;
        endcase
    end

    always_comb begin
        wb_we     = 1'b0;
        wb_data   = sum;
        wb_result = '0;
        if (is_arith) begin
            wb_we     = 1'b1;
            wb_data   = sum;
            wb_result = sum;
        end else if (op_q == OP_MOVI) begin
            wb_we     = 1'b1;
            wb_data   = zext_imm;
            wb_result = zext_imm;
        end else if (op_q == OP_READ) begin
            wb_result = rdata1;
        end
    end

    // Overflow judged on the operand actually presented to the adder.
    assign ovf = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);
    assign new_flags = {cout, (sum == '0), sum[DW-1], ovf};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            cin      <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        imm_q <= imm;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    op_a  <= rdata1;
                    op_b  <= fetch_b;
                    cin   <= fetch_cin;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    sum   <= add_s;
                    cout  <= add_cout;
                    state <= S_WB;
                end
                S_WB: begin
                    done_q   <= 1'b1;
                    err_q    <= is_illegal;
                    result_q <= wb_result;
                    if (is_arith) begin
                        flags_q <= new_flags;
                    end
                    if (wb_we && (rd_q != 4'd0)) begin
                        regs[rd_q] <= wb_data;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready   = (state == S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign result  = result_q;
    assign flags   = flags_q;
    assign add_a   = op_a;
    assign add_b   = op_b;
    assign add_cin = cin;

endmodule
